// File: rtl/q_evt_pkg.sv
// Shared types and default sizing for the q edge window counter slice.
package q_evt_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int STABLE_CYCLES_DEF = 3;
   localparam int WINDOW_DEF        = 16;
   localparam int CNT_W_DEF         = 8;

endpackage

// File: rtl/q_glitch_filter.sv
// Deglitcher for the upstream q bit: filt follows q_in only after STABLE_CYCLES
// consecutive differing samples; rise flags the edge where filt is about to go 1.
module q_glitch_filter
   import q_evt_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic q_in,
   output logic filt,
   output logic rise
);

   localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);

   logic [SW-1:0] stab_cnt;
   logic          flip;

   // flip is the edge at which filt takes the new value, so rise lines up with filt_next
   assign flip = (q_in != filt) && (stab_cnt == STAB_MAX);
   assign rise = flip & q_in;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         filt     <= 1'b0;
         stab_cnt <= '0;
      end else if (q_in == filt) begin
         stab_cnt <= '0;
      end else if (flip) begin
         filt     <= q_in;
         stab_cnt <= '0;
      end else begin
         stab_cnt <= stab_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/q_edge_window_counter.sv
// Counts filtered rising edges of q_in over WINDOW-clock windows and offers each
// window's count downstream on a valid/ready handshake.
//
//   state | meaning
//   IDLE  | paused; window/edge counters hold, next entry starts a fresh window
//   RUN   | window running; win_cnt advances each clock, rises accumulate
module q_edge_window_counter
   import q_evt_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int WINDOW        = WINDOW_DEF,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             q_in,
   input  logic             enable,
   output logic [CNT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun
);

   localparam int WW = $clog2(WINDOW);
   localparam logic [WW-1:0]    WIN_LAST = WW'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state;
   logic [WW-1:0]    win_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] edge_next;
   logic             filt_unused;
   logic             rise;
   logic             win_end;
   logic             accept;

   q_glitch_filter #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_filt (
      .clk  (clk),
      .rst  (rst),
      .q_in (q_in),
      .filt (filt_unused),
      .rise (rise)
   );

   assign edge_next = (rise && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;
   assign win_end   = (state == RUN) && enable && (win_cnt == WIN_LAST);
   assign accept    = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         win_cnt   <= '0;
         edge_cnt  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  state    <= RUN;
                  win_cnt  <= '0;
                  edge_cnt <= '0;
               end
            end
            RUN: begin
               if (!enable) begin
                  state <= IDLE;
               end else if (win_end) begin
                  win_cnt  <= '0;
                  edge_cnt <= '0;
               end else begin
                  win_cnt  <= win_cnt + 1'b1;
                  edge_cnt <= edge_next;
               end
            end
            default: state <= IDLE;
         endcase

         // a result still waiting with no ready is kept; the new snapshot is the one lost
         if (win_end) begin
            if (!out_valid || out_ready) begin
               out_data  <= edge_next;
               out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (accept) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_q_edge_window_counter.sv
// Directed bench for q_edge_window_counter with a result scoreboard.
module tb_q_edge_window_counter;

   logic       clk       = 1'b0;
   logic       rst       = 1'b0;
   logic       q_in      = 1'b0;
   logic       enable    = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       overrun;

   logic       q_in_s      = 1'b0;
   logic       enable_s    = 1'b0;
   logic       out_ready_s = 1'b1;
   logic [1:0] out_data_s;
   logic       out_valid_s;
   logic       overrun_s;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] sb[$];
   logic       exp_valid   = 1'b0;
   logic       exp_overrun = 1'b0;

   always #5 clk = ~clk;

   q_edge_window_counter dut (
      .clk       (clk),
      .rst       (rst),
      .q_in      (q_in),
      .enable    (enable),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   q_edge_window_counter #(
      .STABLE_CYCLES(3),
      .WINDOW       (64),
      .CNT_W        (2)
   ) dut_s (
      .clk       (clk),
      .rst       (rst),
      .q_in      (q_in_s),
      .enable    (enable_s),
      .out_data  (out_data_s),
      .out_valid (out_valid_s),
      .out_ready (out_ready_s),
      .overrun   (overrun_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_a();
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("overrun", 32'(overrun), 32'(exp_overrun));
      if (exp_valid)
         chk("out_data", 32'(out_data), (sb.size() != 0) ? 32'(sb[0]) : 32'hDEAD);
   endtask

   // one clock; the model applies accept / window-end / drop, then checks dut
   task automatic tick(input bit wend);
      bit acc;
      acc = exp_valid && out_ready;
      @(posedge clk);
      #1;
      if (acc) void'(sb.pop_front());
      if (wend) begin
         if (exp_valid && !acc) begin
            void'(sb.pop_back());
            exp_overrun = 1'b1;
         end else begin
            exp_valid = 1'b1;
         end
      end else if (acc) begin
         exp_valid = 1'b0;
      end
      check_a();
   endtask

   // pat[i] / rdy[i] are driven ahead of window edge i+1
   task automatic do_window(input logic [15:0] pat, input logic [15:0] rdy, input logic [7:0] cnt);
      sb.push_back(cnt);
      for (int i = 0; i < 16; i++) begin
         q_in      = pat[i];
         out_ready = rdy[i];
         tick(i == 15);
      end
   endtask

   initial begin
      tick(1'b0);
      tick(1'b0);
      rst = 1'b1;
      tick(1'b0);
      enable = 1'b1;
      tick(1'b0);

      do_window(16'h0003, 16'hFFFF, 8'd0);
      do_window(16'h0007, 16'hFFFF, 8'd1);
      do_window(16'h01C7, 16'hFFFF, 8'd2);
      do_window(16'h0007, 16'h0001, 8'd1);
      do_window(16'h01C7, 16'h8000, 8'd2);
      do_window(16'h0007, 16'h0000, 8'd1);
      do_window(16'h71C7, 16'hFFFF, 8'd3);
      do_window(16'h0000, 16'hFFFF, 8'd0);

      rst = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_s_out_valid", 32'(out_valid_s), 32'd0);
      sb.delete();
      exp_valid   = 1'b0;
      exp_overrun = 1'b0;
      tick(1'b0);
      rst = 1'b1;
      tick(1'b0);
      do_window(16'h0007, 16'hFFFF, 8'd1);

      enable = 1'b0;
      q_in   = 1'b0;
      tick(1'b0);
      tick(1'b0);

      enable_s = 1'b1;
      tick(1'b0);
      for (int i = 0; i < 64; i++) begin
         q_in_s = (i < 30) && ((i % 6) < 3);
         tick(1'b0);
         if (i == 62) chk("sat_valid_early", 32'(out_valid_s), 32'd0);
         if (i == 63) begin
            chk("sat_valid", 32'(out_valid_s), 32'd1);
            chk("sat_data", 32'(out_data_s), 32'd3);
            chk("sat_overrun", 32'(overrun_s), 32'd0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
